// File: rtl/axi_ro_arbiter_if.sv
// Read-only AXI4-Lite bundle: AR and R channels only.
interface axi_ro #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  // Seen from the side that answers reads (accepts AR, returns R).
  modport device (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );

  // Seen from the side that issues reads.
  modport controller (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );
endinterface

// File: rtl/axi_ro_arbiter.sv
// Two-to-one round-robin arbiter for read-only AXI4-Lite, one transaction in flight.
module axi_ro_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  axi_ro.device     s0,
  axi_ro.device     s1,
  axi_ro.controller m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              gnt;
  logic              gnt_nx;
  logic              last;
  logic              last_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic              any_req;
  logic              both_req;
  logic              pick;
  logic              sel_rready;
  logic [DATA_W-1:0] rdata_c;

  // Arbitration decision: a lone requester wins, a tie goes to the source not served last.
  assign any_req  = s0.arvalid | s1.arvalid;
  assign both_req = s0.arvalid & s1.arvalid;
  assign pick     = both_req ? ~last : s1.arvalid;

  // Read data fans out to both sources; only the one seeing rvalid consumes it.
  assign rdata_c  = m.rdata;
  assign s0.rdata = rdata_c;
  assign s1.rdata = rdata_c;

  // Downstream address comes straight from the latched request.
  assign m.araddr = addr_q;

  // Ready of whichever source currently owns the R channel.
  assign sel_rready = gnt ? s1.rready : s0.rready;

  // State, grant, fairness and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      last   <= 1'b1;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      last   <= last_nx;
      addr_q <= addr_nx;
    end
  end

  // Next-state logic and channel routing to the granted source.
  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    last_nx    = last;
    addr_nx    = addr_q;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s1.rvalid  = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nx   = pick;
          addr_nx  = pick ? s1.araddr : s0.araddr;
          state_nx = ADDR;
        end
      end

      ADDR: begin
        m.arvalid  = 1'b1;
        s0.arready = ~gnt & m.arready;
        s1.arready =  gnt & m.arready;
        if (m.arready) begin
          state_nx = DATA;
        end
      end

      DATA: begin
        m.rready  = sel_rready;
        s0.rvalid = ~gnt & m.rvalid;
        s1.rvalid =  gnt & m.rvalid;
        if (m.rvalid && sel_rready) begin
          last_nx  = gnt;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_ro_arbiter.sv
// Self-checking bench for axi_ro_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against an ownership-based reference model.
module tb_axi_ro_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned VW = 1 + AW + 1 + 4 + 2 * DW;

  logic clk;
  logic rst;

  axi_ro #(.ADDR_W(AW), .DATA_W(DW)) s0_if ();
  axi_ro #(.ADDR_W(AW), .DATA_W(DW)) s1_if ();
  axi_ro #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  axi_ro_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .s0  (s0_if),
    .s1  (s1_if),
    .m   (m_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, whether its address is still pending,
  // who was served last, and the address currently presented downstream.
  int          owner    = -1;
  bit          in_addr  = 1'b0;
  int          last_src = 1;
  logic [31:0] held     = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 1000000", $time);
    $fatal(1);
  end

  task automatic model_step();
    bit a0;
    bit a1;
    bit own_rready;
    a0 = (s0_if.arvalid === 1'b1);
    a1 = (s1_if.arvalid === 1'b1);
    if (rst) begin
      owner = -1; in_addr = 1'b0; last_src = 1; held = '0;
    end else if (owner < 0) begin
      if (a0 || a1) begin
        if (a0 && a1) owner = 1 - last_src;
        else          owner = a1 ? 1 : 0;
        held    = (owner == 1) ? s1_if.araddr : s0_if.araddr;
        in_addr = 1'b1;
      end
    end else if (in_addr) begin
      if (m_if.arready) in_addr = 1'b0;
    end else begin
      own_rready = (owner == 1) ? s1_if.rready : s0_if.rready;
      if (m_if.rvalid && own_rready) begin
        last_src = owner;
        owner    = -1;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic arv, rr, ar0, ar1, rv0, rv1;
    arv = (owner >= 0) && in_addr;
    ar0 = arv && (owner == 0) && m_if.arready;
    ar1 = arv && (owner == 1) && m_if.arready;
    rv0 = (owner == 0) && !in_addr && m_if.rvalid;
    rv1 = (owner == 1) && !in_addr && m_if.rvalid;
    rr  = (owner >= 0) && !in_addr && ((owner == 1) ? s1_if.rready : s0_if.rready);
    return {arv, held, rr, ar0, ar1, rv0, rv1, m_if.rdata, m_if.rdata};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {m_if.arvalid, m_if.araddr, m_if.rready, s0_if.arready, s1_if.arready,
            s0_if.rvalid, s1_if.rvalid, s0_if.rdata, s1_if.rdata};
  endfunction

  // Advance one clock; the model samples the same inputs the DUT sees at the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s0_if.araddr = '0; s0_if.arvalid = 1'b0; s0_if.rready = 1'b0;
    s1_if.araddr = '0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b0;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m_if.arready = 1'b1; m_if.rvalid = 1'b1;
    s0_if.rready = 1'b1; s1_if.rready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({m_if.arvalid, m_if.araddr, m_if.rready, s0_if.arready, s1_if.arready,
         s0_if.rvalid, s1_if.rvalid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got arv=%b araddr=%h rready=%b ar0=%b ar1=%b rv0=%b rv1=%b, required all 0",
               m_if.arvalid, m_if.araddr, m_if.rready, s0_if.arready, s1_if.arready,
               s0_if.rvalid, s1_if.rvalid);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_s0();
    do_reset();
    s0_if.araddr = 32'h0000_0100; s0_if.arvalid = 1'b1; s0_if.rready = 1'b1;
    m_if.arready = 1'b1;
    #1;
    checks++;
    if ({m_if.arvalid, s0_if.arready} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got arv=%b ar0=%b, required 0 0", m_if.arvalid, s0_if.arready);
    end
    tick();
    #1;
    checks++;
    if ({m_if.arvalid, m_if.araddr, s0_if.arready, s1_if.arready} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_addr: got arv=%b araddr=%h ar0=%b ar1=%b, required 1 00000100 1 0",
               m_if.arvalid, m_if.araddr, s0_if.arready, s1_if.arready);
    end
    tick();
    s0_if.arvalid = 1'b0; m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({s0_if.rvalid, s0_if.rdata, s1_if.rvalid, s1_if.arready, m_if.rready} !==
        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_data: got rv0=%b rdata=%h rv1=%b ar1=%b rready=%b, required 1 deadbeef 0 0 1",
               s0_if.rvalid, s0_if.rdata, s1_if.rvalid, s1_if.arready, m_if.rready);
    end
    tick();
    m_if.rvalid = 1'b0;
    #1;
    checks++;
    if ({m_if.arvalid, m_if.rready, s0_if.rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL single_done: got arv=%b rready=%b rv0=%b, required 0 0 0",
               m_if.arvalid, m_if.rready, s0_if.rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [31:0] addr_log[$];
    int          src_log[$];
    logic [31:0] exp_addr [4] = '{32'h10, 32'h20, 32'h10, 32'h20};
    do_reset();
    s0_if.araddr = 32'h10; s0_if.arvalid = 1'b1; s0_if.rready = 1'b1;
    s1_if.araddr = 32'h20; s1_if.arvalid = 1'b1; s1_if.rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b1;
    for (int c = 0; c < 40 && addr_log.size() < 4; c++) begin
      m_if.rdata = $urandom;
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rr_cycle%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      if (m_if.arvalid && m_if.arready) begin
        addr_log.push_back(m_if.araddr);
        src_log.push_back(s1_if.arready ? 1 : 0);
      end
      tick();
    end
    checks++;
    if (addr_log.size() != 4) begin
      errors++;
      $display("FAIL rr_timeout: got %0d grants required 4", addr_log.size());
    end
    for (int i = 0; i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== exp_addr[i] || src_log[i] != (i % 2)) begin
        errors++;
        $display("FAIL rr_order%0d: got src=%0d addr=%h required src=%0d addr=%h",
                 i, src_log[i], addr_log[i], i % 2, exp_addr[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_delayed_arready();
    logic [31:0] d;
    do_reset();
    s1_if.araddr = 32'h8000_0004; s1_if.arvalid = 1'b1; s1_if.rready = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      m_if.arready = (k == 4);
      #1;
      checks++;
      if ({m_if.arvalid, m_if.araddr, s1_if.arready, s0_if.arready} !==
          {1'b1, 32'h8000_0004, (k == 4), 1'b0}) begin
        errors++;
        $display("FAIL delay_addr%0d: got arv=%b araddr=%h ar1=%b ar0=%b, required 1 80000004 %0d 0",
                 k, m_if.arvalid, m_if.araddr, s1_if.arready, s0_if.arready, (k == 4));
      end
      tick();
    end
    d = $urandom;
    s1_if.arvalid = 1'b0; m_if.arready = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = d;
    #1;
    checks++;
    if ({s1_if.rvalid, s1_if.rdata, s0_if.rvalid, m_if.rready} !== {1'b1, d, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL delay_data: got rv1=%b rdata=%h rv0=%b rready=%b, required 1 %h 0 1",
               s1_if.rvalid, s1_if.rdata, s0_if.rvalid, m_if.rready, d);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    s0_if.araddr = 32'h44; s0_if.arvalid = 1'b1; m_if.arready = 1'b1;
    tick();
    tick();
    s0_if.arvalid = 1'b0; m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; s0_if.rready = 1'b0; m_if.rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({m_if.rready, s0_if.rvalid} !== 2'b01) begin
        errors++;
        $display("FAIL bp_stall%0d: got rready=%b rv0=%b, required 0 1", k, m_if.rready, s0_if.rvalid);
      end
      tick();
    end
    s0_if.rready = 1'b1;
    #1;
    checks++;
    if ({m_if.rready, s0_if.rvalid} !== 2'b11) begin
      errors++;
      $display("FAIL bp_accept: got rready=%b rv0=%b, required 1 1", m_if.rready, s0_if.rvalid);
    end
    tick();
    #1;
    checks++;
    if ({m_if.arvalid, m_if.rready, s0_if.rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL bp_idle: got arv=%b rready=%b rv0=%b, required 0 0 0",
               m_if.arvalid, m_if.rready, s0_if.rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_data();
    do_reset();
    // Serve s0 first so that, without reset, a tie would go to s1.
    s0_if.araddr = 32'h100; s0_if.arvalid = 1'b1; s0_if.rready = 1'b1; m_if.arready = 1'b1;
    tick();
    tick();
    s0_if.arvalid = 1'b0; m_if.rvalid = 1'b1;
    tick();
    m_if.rvalid = 1'b0;
    s1_if.araddr = 32'h200; s1_if.arvalid = 1'b1; s1_if.rready = 1'b1;
    tick();
    tick();
    s1_if.arvalid = 1'b0; m_if.arready = 1'b0;
    #1;
    checks++;
    if ({m_if.rready, s1_if.rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_in_data_pre: got rready=%b rv1=%b, required 1 0", m_if.rready, s1_if.rvalid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_if.arready = 1'b1; m_if.rvalid = 1'b1;
    #1;
    checks++;
    if ({m_if.arvalid, m_if.araddr, m_if.rready, s0_if.arready, s1_if.arready,
         s0_if.rvalid, s1_if.rvalid} !== '0) begin
      errors++;
      $display("FAIL rst_in_data_clear: got arv=%b araddr=%h rready=%b ar0=%b ar1=%b rv0=%b rv1=%b, required all 0",
               m_if.arvalid, m_if.araddr, m_if.rready, s0_if.arready, s1_if.arready,
               s0_if.rvalid, s1_if.rvalid);
    end
    m_if.rvalid = 1'b0;
    s0_if.araddr = 32'h300; s0_if.arvalid = 1'b1;
    s1_if.araddr = 32'h400; s1_if.arvalid = 1'b1;
    tick();
    #1;
    checks++;
    if ({m_if.araddr, s0_if.arready, s1_if.arready} !== {32'h300, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_in_data_regrant: got araddr=%h ar0=%b ar1=%b, required 00000300 1 0",
               m_if.araddr, s0_if.arready, s1_if.arready);
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int src_log[$];
    bit drop1;
    do_reset();
    s0_if.araddr = 32'h10; s0_if.arvalid = 1'b1; s0_if.rready = 1'b1;
    s1_if.rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b1;
    for (int c = 0; c < 30 && src_log.size() < 3; c++) begin
      if (c == 1) begin
        s1_if.araddr = 32'h20; s1_if.arvalid = 1'b1;
      end
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL starve_cycle%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      drop1 = s1_if.arready;
      if (m_if.arvalid && m_if.arready) src_log.push_back(s1_if.arready ? 1 : 0);
      tick();
      if (drop1) s1_if.arvalid = 1'b0;
    end
    checks++;
    if (src_log.size() != 3) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants required 3", src_log.size());
    end else begin
      checks++;
      if (src_log[0] != 0 || src_log[1] != 1 || src_log[2] != 0) begin
        errors++;
        $display("FAIL starve_order: got %0d %0d %0d required 0 1 0", src_log[0], src_log[1], src_log[2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int waits0 = 0;
    int waits1 = 0;
    bit drop0, drop1, was_rst;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!s0_if.arvalid && $urandom_range(0, 2) == 0) begin
        s0_if.arvalid = 1'b1; s0_if.araddr = $urandom;
      end
      if (!s1_if.arvalid && $urandom_range(0, 2) == 0) begin
        s1_if.arvalid = 1'b1; s1_if.araddr = $urandom;
      end
      s0_if.rready = 1'($urandom_range(0, 1));
      s1_if.rready = 1'($urandom_range(0, 1));
      m_if.arready = 1'($urandom_range(0, 1));
      m_if.rvalid  = 1'($urandom_range(0, 1));
      m_if.rdata   = $urandom;
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cycle%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      was_rst = rst;
      drop0 = s0_if.arvalid && s0_if.arready && !rst;
      drop1 = s1_if.arvalid && s1_if.arready && !rst;
      if (drop0) begin
        checks++;
        if (waits0 > 1) begin
          errors++;
          $display("FAIL rand_starve_s0: got %0d other grants while waiting, required <= 1", waits0);
        end
        waits0 = 0;
        if (s1_if.arvalid) waits1++;
      end
      if (drop1) begin
        checks++;
        if (waits1 > 1) begin
          errors++;
          $display("FAIL rand_starve_s1: got %0d other grants while waiting, required <= 1", waits1);
        end
        waits1 = 0;
        if (s0_if.arvalid) waits0++;
      end
      tick();
      if (was_rst) begin
        waits0 = 0; waits1 = 0;
        s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
      end
      if (drop0) s0_if.arvalid = 1'b0;
      if (drop1) s1_if.arvalid = 1'b0;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_s0();
    test_round_robin();
    test_delayed_arready();
    test_backpressure();
    test_reset_in_data();
    test_starvation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
